// File: rtl/bitty_run_ctrl.sv
// Run-control sequencer for the bitty core: free-run, single-step, halt/drain,
// breakpoint and instruction-budget stops, watchdog fault, retire/cycle counters.
module bitty_run_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             step,
   input  logic             halt,
   input  logic             clear,
   input  logic             instr_done,
   input  logic [7:0]       pc,
   input  logic             bp_en,
   input  logic [7:0]       bp_addr,
   input  logic [CNT_W-1:0] limit,
   output logic             core_run,
   output logic [2:0]       state,
   output logic             bp_hit,
   output logic             limit_hit,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_STEP   = 3'd2,
      S_DRAIN  = 3'd3,
      S_HALTED = 3'd4,
      S_FAULT  = 3'd5
   } state_e;

   localparam int              WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic             core_run_q, core_run_d;
   logic             bp_hit_q, bp_hit_d;
   logic             limit_hit_q, limit_hit_d;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
   logic [WD_W-1:0]  wdog_q, wdog_d;

   logic             active;
   logic             bp_match;
   logic             lim_match;
   logic             wd_expire;
   logic [CNT_W-1:0] icnt_inc;
   logic [CNT_W-1:0] ccnt_inc;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d       = state_q;
      bp_hit_d      = 1'b0;
      limit_hit_d   = 1'b0;
      instr_count_d = instr_count_q;
      cycle_count_d = cycle_count_q;
      wdog_d        = '0;

      active    = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
      icnt_inc  = (&instr_count_q) ? instr_count_q : instr_count_q + CNT_W'(1);
      ccnt_inc  = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);
      bp_match  = bp_en && (pc == bp_addr);
      lim_match = (limit != '0) && (icnt_inc == limit);
      wd_expire = !instr_done && (wdog_q == WD_LAST);

      if (active) begin
         cycle_count_d = ccnt_inc;
         wdog_d        = instr_done ? '0 : wdog_q + WD_W'(1);
         if (instr_done) instr_count_d = icnt_inc;
      end

      case (state_q)
         S_IDLE, S_HALTED: begin
            if ((state_q == S_HALTED) && clear) begin
               state_d       = S_IDLE;
               instr_count_d = '0;
               cycle_count_d = '0;
            end else if (!halt) begin
               if (step)       state_d = S_STEP;
               else if (start) state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (instr_done) begin
               if (halt || bp_match || lim_match) begin
                  state_d     = S_HALTED;
                  bp_hit_d    = bp_match;
                  limit_hit_d = lim_match;
               end
            end else if (wd_expire) begin
               state_d = S_FAULT;
            end else if (halt) begin
               state_d = S_DRAIN;
            end
         end
         // Breakpoints are deliberately not evaluated while stepping.
         S_STEP, S_DRAIN: begin
            if (instr_done)     state_d = S_HALTED;
            else if (wd_expire) state_d = S_FAULT;
         end
         S_FAULT: begin
            if (clear) begin
               state_d       = S_IDLE;
               instr_count_d = '0;
               cycle_count_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      core_run_d = (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
      if (!core_run_d) wdog_d = '0;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         core_run_q    <= 1'b0;
         bp_hit_q      <= 1'b0;
         limit_hit_q   <= 1'b0;
         instr_count_q <= '0;
         cycle_count_q <= '0;
         wdog_q        <= '0;
      end else begin
         state_q       <= state_d;
         core_run_q    <= core_run_d;
         bp_hit_q      <= bp_hit_d;
         limit_hit_q   <= limit_hit_d;
         instr_count_q <= instr_count_d;
         cycle_count_q <= cycle_count_d;
         wdog_q        <= wdog_d;
      end
   end

   assign core_run    = core_run_q;
   assign state       = state_q;
   assign bp_hit      = bp_hit_q;
   assign limit_hit   = limit_hit_q;
   assign instr_count = instr_count_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_bitty_run_ctrl.sv
// Self-checking bench for bitty_run_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a rule-level reference model.
module tb_bitty_run_ctrl;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 16;
   localparam int SAT     = (1 << CNT_W) - 1;

   localparam int IDLE = 0, RUN = 1, STEP = 2, DRAIN = 3, HALTED = 4, FAULT = 5;

   logic             clk;
   logic             reset, start, step, halt, clear, instr_done, bp_en;
   logic [7:0]       pc, bp_addr;
   logic [CNT_W-1:0] limit;
   logic             core_run, bp_hit, limit_hit;
   logic [2:0]       state;
   logic [CNT_W-1:0] instr_count, cycle_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int m_state = IDLE;
   int m_ic = 0, m_cc = 0, m_quiet = 0;
   bit m_run = 0, m_bp = 0, m_lim = 0;

   // Pulse / run-cycle tallies for directed scenarios
   int bp_pulses, lim_pulses, run_cycles;

   bitty_run_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .step(step), .halt(halt),
      .clear(clear), .instr_done(instr_done), .pc(pc), .bp_en(bp_en),
      .bp_addr(bp_addr), .limit(limit), .core_run(core_run), .state(state),
      .bp_hit(bp_hit), .limit_hit(limit_hit), .instr_count(instr_count),
      .cycle_count(cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit busy(input int s);
      return (s == RUN) || (s == STEP) || (s == DRAIN);
   endfunction

   function automatic int bump(input int v);
      return (v >= SAT) ? SAT : v + 1;
   endfunction

   // Apply the controller's rules to the inputs present at this clock edge.
   task automatic model_step();
      int ns = m_state;
      int ic = m_ic, cc = m_cc, quiet = 0;
      bit hit_bp = 0, hit_lim = 0;
      if (reset) begin
         ns = IDLE; ic = 0; cc = 0;
      end else begin
         if (busy(m_state)) begin
            cc = bump(m_cc);
            if (instr_done) ic = bump(m_ic);
            quiet = instr_done ? 0 : m_quiet + 1;
         end
         if (m_state == IDLE || m_state == HALTED) begin
            if (m_state == HALTED && clear) begin
               ns = IDLE; ic = 0; cc = 0;
            end else if (halt) ns = m_state;
            else if (step)     ns = STEP;
            else if (start)    ns = RUN;
         end else if (m_state == FAULT) begin
            if (clear) begin ns = IDLE; ic = 0; cc = 0; end
         end else if (instr_done) begin
            if (m_state == RUN) begin
               hit_bp  = bp_en && (pc == bp_addr);
               hit_lim = (int'(limit) != 0) && (ic == int'(limit));
               if (halt || hit_bp || hit_lim) ns = HALTED;
            end else ns = HALTED;
         end else if (quiet >= TIMEOUT) ns = FAULT;
         else if (m_state == RUN && halt) ns = DRAIN;
      end
      if (!busy(ns)) quiet = 0;
      m_state = ns; m_ic = ic; m_cc = cc; m_quiet = quiet;
      m_bp = hit_bp; m_lim = hit_lim; m_run = busy(ns);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("state",       32'(state),       32'(m_state));
      chk("core_run",    32'(core_run),    32'(m_run));
      chk("bp_hit",      32'(bp_hit),      32'(m_bp));
      chk("limit_hit",   32'(limit_hit),   32'(m_lim));
      chk("instr_count", 32'(instr_count), 32'(m_ic));
      chk("cycle_count", 32'(cycle_count), 32'(m_cc));
      if (bp_hit)    bp_pulses++;
      if (limit_hit) lim_pulses++;
      if (core_run)  run_cycles++;
   endtask

   task automatic quiet_inputs();
      reset = 0; start = 0; step = 0; halt = 0; clear = 0; instr_done = 0;
   endtask

   task automatic zero_tallies();
      bp_pulses = 0; lim_pulses = 0; run_cycles = 0;
   endtask

   initial begin
      int iters;
      quiet_inputs();
      reset = 1; pc = 0; bp_en = 0; bp_addr = 0; limit = 0;
      zero_tallies();

      // Reset state
      tick(); tick();
      reset = 0;
      tick();
      chk("rst_state", 32'(state), 0);
      chk("rst_run",   32'(core_run), 0);
      chk("rst_icnt",  32'(instr_count), 0);
      chk("rst_ccnt",  32'(cycle_count), 0);

      // Single step with instruction completing three cycles in
      zero_tallies();
      step = 1; tick(); step = 0;
      chk("step_state", 32'(state), STEP);
      tick(); tick();
      instr_done = 1; tick(); instr_done = 0;
      chk("step_halted", 32'(state), HALTED);
      chk("step_icnt",   32'(instr_count), 1);
      chk("step_ccnt",   32'(cycle_count), 3);
      chk("step_runcyc", 32'(run_cycles), 3);
      clear = 1; tick(); clear = 0;
      chk("clr_state", 32'(state), IDLE);
      chk("clr_icnt",  32'(instr_count), 0);

      // Breakpoint at 0x05, then step off it
      bp_en = 1; bp_addr = 8'h05; zero_tallies();
      start = 1; tick(); start = 0;
      for (int k = 1; k <= 5; k++) begin
         pc = 8'(k); instr_done = 1; tick(); instr_done = 0;
         if (k < 5) tick();
      end
      chk("bp_state", 32'(state), HALTED);
      chk("bp_pulse", 32'(bp_hit), 1);
      chk("bp_icnt",  32'(instr_count), 5);
      tick();
      chk("bp_pulses", 32'(bp_pulses), 1);
      step = 1; tick(); step = 0;
      pc = 8'h05; instr_done = 1; tick(); instr_done = 0;
      chk("bpstep_state", 32'(state), HALTED);
      chk("bpstep_hit",   32'(bp_hit), 0);
      chk("bpstep_icnt",  32'(instr_count), 6);
      chk("bpstep_pulses", 32'(bp_pulses), 1);
      bp_en = 0;

      // Instruction budget of four
      clear = 1; tick(); clear = 0;
      limit = 4; zero_tallies();
      start = 1; tick(); start = 0;
      instr_done = 1; iters = 0;
      while (iters < 20) begin
         tick(); iters++;
         if (state == 3'(HALTED)) break;
      end
      chk("lim_iters", 32'(iters), 4);
      chk("lim_pulse", 32'(limit_hit), 1);
      chk("lim_icnt",  32'(instr_count), 4);
      tick(); instr_done = 0; tick();
      chk("lim_pulses", 32'(lim_pulses), 1);
      chk("lim_icnt2",  32'(instr_count), 4);
      limit = 0;

      // Halt two cycles ahead of completion drains, then combined commands in HALTED
      clear = 1; tick(); clear = 0;
      start = 1; tick(); start = 0;
      tick();
      halt = 1; tick(); halt = 0;
      chk("drain_state", 32'(state), DRAIN);
      chk("drain_run",   32'(core_run), 1);
      tick();
      chk("drain_hold", 32'(state), DRAIN);
      instr_done = 1; tick(); instr_done = 0;
      chk("drain_halted", 32'(state), HALTED);
      halt = 1; step = 1; start = 1; tick(); quiet_inputs();
      chk("hss_state", 32'(state), HALTED);
      chk("hss_run",   32'(core_run), 0);

      // Watchdog fault after TIMEOUT idle cycles
      clear = 1; tick(); clear = 0;
      start = 1; tick(); start = 0;
      repeat (TIMEOUT - 1) tick();
      chk("wd_still_run", 32'(state), RUN);
      tick();
      chk("wd_fault", 32'(state), FAULT);
      chk("wd_run",   32'(core_run), 0);
      chk("wd_ccnt",  32'(cycle_count), TIMEOUT);
      start = 1; tick(); start = 0;
      chk("fault_sticky", 32'(state), FAULT);
      clear = 1; tick(); clear = 0;
      chk("fault_clr", 32'(state), IDLE);
      chk("fault_icnt", 32'(instr_count), 0);
      chk("fault_ccnt", 32'(cycle_count), 0);

      // Reset mid-instruction in RUN
      start = 1; tick(); start = 0;
      tick(); tick();
      reset = 1; tick(); reset = 0;
      chk("mid_rst_state", 32'(state), IDLE);
      chk("mid_rst_run",   32'(core_run), 0);
      chk("mid_rst_ccnt",  32'(cycle_count), 0);
      tick();
      chk("post_rst_bp",  32'(bp_hit), 0);
      chk("post_rst_lim", 32'(limit_hit), 0);

      // Random traffic against the model
      for (int seg = 0; seg < 20; seg++) begin
         int density;
         density = int'($urandom_range(0, 7));
         bp_en   = 1'($urandom_range(0, 1));
         bp_addr = 8'($urandom_range(0, 7));
         limit   = CNT_W'($urandom_range(0, 6));
         for (int c = 0; c < 150; c++) begin
            reset      = ($urandom_range(0, 99) == 0);
            clear      = ($urandom_range(0, 15) == 0);
            start      = ($urandom_range(0, 7) == 0);
            step       = ($urandom_range(0, 7) == 0);
            halt       = ($urandom_range(0, 11) == 0);
            instr_done = (int'($urandom_range(0, 7)) < density);
            pc         = 8'($urandom_range(0, 7));
            tick();
         end
      end
      quiet_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
